// File: rtl/ysyx_210544_cmt_monitor_pkg.sv
// Shared constants and types for the commit-stream monitor: trap encoding,
// the a0 register index and the monitor state encoding.
package ysyx_210544_cmt_monitor_pkg;

  localparam logic [6:0] TRAP_OPCODE = 7'h6b;
  localparam logic [4:0] A0_IDX      = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  function automatic logic is_trap_inst(input logic [31:0] inst);
    return inst[6:0] == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/ysyx_210544_cmt_shadow_rf.sv
// Shadow integer register file: x1..x31, one write port, one registered read
// port, x0 reads as zero; also exposes a0[2:0] combinationally for the trap code.
module ysyx_210544_cmt_shadow_rf
  import ysyx_210544_cmt_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [63:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [63:0] o_rdata,
  output logic [2:0]  o_a0_code
);

  logic [63:0] rf_q [1:31];
  logic [63:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (i_we && (i_waddr != 5'd0)) begin
        rf_q[i_waddr] <= i_wdata;
      end
      // Reads sample the pre-edge contents, so a same-edge write returns the old value.
      rdata_q <= (i_raddr == 5'd0) ? 64'd0 : rf_q[i_raddr];
    end
  end

  assign o_rdata   = rdata_q;
  assign o_a0_code = rf_q[A0_IDX][2:0];

endmodule

// File: rtl/ysyx_210544_cmt_monitor.sv
// Commit-stream monitor: shadow register file, cycle/instruction/interrupt
// counters, halt-trap detection and a commit-stall watchdog with pass/fail verdict.
module ysyx_210544_cmt_monitor
  import ysyx_210544_cmt_monitor_pkg::*;
#(
  parameter int unsigned IDLE_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmt_valid,
  input  logic        i_cmt_skip,
  input  logic [63:0] i_cmt_pc,
  input  logic [31:0] i_cmt_inst,
  input  logic        i_cmt_wen,
  input  logic [4:0]  i_cmt_wdest,
  input  logic [63:0] i_cmt_wdata,
  input  logic [31:0] i_intrNo,
  input  logic [4:0]  i_gpr_raddr,
  output logic [63:0] o_gpr_rdata,
  output logic        o_running,
  output logic        o_done,
  output logic        o_pass,
  output logic [2:0]  o_trap_code,
  output logic        o_timeout,
  output logic        o_pc_misalign,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instr_cnt,
  output logic [31:0] o_intr_cnt,
  output logic [63:0] o_last_pc
);

  localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);

  mon_state_e  state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instr_q, instr_d;
  logic [31:0] intr_q, intr_d;
  logic [63:0] last_pc_q, last_pc_d;
  logic [2:0]  code_q, code_d;
  logic        pass_q, pass_d;
  logic        misalign_q, misalign_d;

  logic        accepted;
  logic        is_intr;
  logic        is_trap;
  logic        rf_we;
  logic [2:0]  a0_code;

  // Skip records are treated like any other; upper opcode bits are not decoded.
  logic unused_inputs;
  assign unused_inputs = ^{i_cmt_skip, i_cmt_inst[31:7]};

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    intr_d     = intr_q;
    last_pc_d  = last_pc_q;
    code_d     = code_q;
    pass_d     = pass_q;
    misalign_d = misalign_q;

    accepted = i_cmt_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    is_intr  = i_intrNo != 32'd0;
    is_trap  = accepted && !is_intr && is_trap_inst(i_cmt_inst);
    rf_we    = accepted && !is_intr && !is_trap && i_cmt_wen;

    case (state_q)
      ST_IDLE: begin
        if (accepted) state_d = is_trap ? ST_HALT : ST_RUN;
      end
      ST_RUN: begin
        // An accepted record always beats watchdog expiry in the same cycle.
        if (accepted) begin
          state_d = is_trap ? ST_HALT : ST_RUN;
        end else if (idle_q == IDLE_W'(IDLE_LIMIT - 1)) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase

    if (accepted || (state_q == ST_RUN)) cycle_d = cycle_q + 64'd1;

    if (accepted) begin
      idle_d = '0;
    end else if (state_q == ST_RUN) begin
      idle_d = idle_q + 1'b1;
    end

    if (accepted) begin
      last_pc_d = i_cmt_pc;
      if (is_intr) begin
        intr_d = intr_q + 32'd1;
      end else begin
        instr_d = instr_q + 64'd1;
        if (i_cmt_pc[1:0] != 2'b00) misalign_d = 1'b1;
      end
    end

    if (is_trap) begin
      code_d = a0_code;
      pass_d = a0_code == 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idle_q     <= '0;
      cycle_q    <= '0;
      instr_q    <= '0;
      intr_q     <= '0;
      last_pc_q  <= '0;
      code_q     <= '0;
      pass_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      intr_q     <= intr_d;
      last_pc_q  <= last_pc_d;
      code_q     <= code_d;
      pass_q     <= pass_d;
      misalign_q <= misalign_d;
    end
  end

  ysyx_210544_cmt_shadow_rf u_shadow_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (rf_we),
    .i_waddr   (i_cmt_wdest),
    .i_wdata   (i_cmt_wdata),
    .i_raddr   (i_gpr_raddr),
    .o_rdata   (o_gpr_rdata),
    .o_a0_code (a0_code)
  );

  assign o_running     = state_q == ST_RUN;
  assign o_done        = state_q == ST_HALT;
  assign o_timeout     = state_q == ST_TIMEOUT;
  assign o_pass        = pass_q;
  assign o_trap_code   = code_q;
  assign o_pc_misalign = misalign_q;
  assign o_cycle_cnt   = cycle_q;
  assign o_instr_cnt   = instr_q;
  assign o_intr_cnt    = intr_q;
  assign o_last_pc     = last_pc_q;

endmodule

// File: tb/tb_ysyx_210544_cmt_monitor.sv
// Bench for the commit monitor: directed scenarios plus randomized record
// streams compared every cycle against a behavioural model.
module tb_ysyx_210544_cmt_monitor;

  localparam int unsigned LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmt_valid, i_cmt_skip, i_cmt_wen;
  logic [63:0] i_cmt_pc, i_cmt_wdata;
  logic [31:0] i_cmt_inst, i_intrNo;
  logic [4:0]  i_cmt_wdest, i_gpr_raddr;
  logic [63:0] o_gpr_rdata, o_cycle_cnt, o_instr_cnt, o_last_pc;
  logic        o_running, o_done, o_pass, o_timeout, o_pc_misalign;
  logic [2:0]  o_trap_code;
  logic [31:0] o_intr_cnt;

  always #5 clk = ~clk;

  ysyx_210544_cmt_monitor #(.IDLE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_cmt_valid(i_cmt_valid), .i_cmt_skip(i_cmt_skip), .i_cmt_pc(i_cmt_pc),
    .i_cmt_inst(i_cmt_inst), .i_cmt_wen(i_cmt_wen), .i_cmt_wdest(i_cmt_wdest),
    .i_cmt_wdata(i_cmt_wdata), .i_intrNo(i_intrNo), .i_gpr_raddr(i_gpr_raddr),
    .o_gpr_rdata(o_gpr_rdata), .o_running(o_running), .o_done(o_done),
    .o_pass(o_pass), .o_trap_code(o_trap_code), .o_timeout(o_timeout),
    .o_pc_misalign(o_pc_misalign), .o_cycle_cnt(o_cycle_cnt),
    .o_instr_cnt(o_instr_cnt), .o_intr_cnt(o_intr_cnt), .o_last_pc(o_last_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: "started" = a record has been seen, "done"/"timed_out" end the run.
  bit          m_started, m_done, m_to, m_pass, m_mis;
  logic [2:0]  m_code;
  logic [63:0] m_cyc, m_instr, m_last_pc, m_rdata;
  logic [31:0] m_intr;
  logic [63:0] m_rf [32];
  int          m_idle;

  task automatic model_reset();
    m_started = 0; m_done = 0; m_to = 0; m_pass = 0; m_mis = 0;
    m_code = '0; m_cyc = '0; m_instr = '0; m_last_pc = '0; m_rdata = '0;
    m_intr = '0; m_idle = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  task automatic model_step();
    m_rdata = m_rf[i_gpr_raddr];
    if (m_done || m_to) return;
    if (i_cmt_valid) begin
      m_started = 1;
      m_cyc++;
      m_idle = 0;
      m_last_pc = i_cmt_pc;
      if (i_intrNo != 0) begin
        m_intr++;
      end else begin
        m_instr++;
        if (i_cmt_pc[1:0] != 0) m_mis = 1;
        if (i_cmt_inst[6:0] == 7'h6b) begin
          m_done = 1;
          m_code = m_rf[10][2:0];
          m_pass = (m_code == 0);
        end else if (i_cmt_wen && i_cmt_wdest != 0) begin
          m_rf[i_cmt_wdest] = i_cmt_wdata;
        end
      end
    end else if (m_started) begin
      m_cyc++;
      m_idle++;
      if (m_idle == LIM) m_to = 1;
    end
  endtask

  task automatic check_all();
    chk("running",  64'(o_running),     64'(m_started && !m_done && !m_to));
    chk("done",     64'(o_done),        64'(m_done));
    chk("pass",     64'(o_pass),        64'(m_pass));
    chk("trapcode", 64'(o_trap_code),   64'(m_code));
    chk("timeout",  64'(o_timeout),     64'(m_to));
    chk("misalign", 64'(o_pc_misalign), 64'(m_mis));
    chk("cycles",   o_cycle_cnt,        m_cyc);
    chk("instrs",   o_instr_cnt,        m_instr);
    chk("intrs",    64'(o_intr_cnt),    64'(m_intr));
    chk("last_pc",  o_last_pc,          m_last_pc);
    chk("rdata",    o_gpr_rdata,        m_rdata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rec(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                     input logic [4:0] wd, input logic [63:0] wdat, input logic [31:0] intr);
    i_cmt_valid = 1'b1; i_cmt_skip = 1'b0; i_cmt_pc = pc; i_cmt_inst = inst;
    i_cmt_wen = wen; i_cmt_wdest = wd; i_cmt_wdata = wdat; i_intrNo = intr;
    cycle();
  endtask

  task automatic idle();
    i_cmt_valid = 1'b0;
    cycle();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    i_cmt_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    i_cmt_valid = 0; i_cmt_skip = 0; i_cmt_pc = 0; i_cmt_inst = 0; i_cmt_wen = 0;
    i_cmt_wdest = 0; i_cmt_wdata = 0; i_intrNo = 0; i_gpr_raddr = 0;
    #2;
    reset_dut();

    // Long silence before any record: watchdog must stay off.
    for (int i = 0; i < 10000; i++) idle();
    chk("idle_timeout", 64'(o_timeout), 64'd0);
    chk("idle_cycles", o_cycle_cnt, 64'd0);

    // Passing program.
    reset_dut();
    rec(64'h80000000, 32'h00000513, 1'b1, 5'd10, 64'd0, 32'd0);
    rec(64'h80000004, 32'h0000006b, 1'b0, 5'd0, 64'd0, 32'd0);
    chk("pass_done", 64'(o_done), 64'd1);
    chk("pass_pass", 64'(o_pass), 64'd1);
    chk("pass_instr", o_instr_cnt, 64'd2);
    chk("pass_cycle", o_cycle_cnt, 64'd2);

    // Failing program, then frozen state; trap write to a0 is ignored.
    reset_dut();
    rec(64'h80000000, 32'h00500513, 1'b1, 5'd10, 64'd5, 32'd0);
    rec(64'h80000004, 32'h0000006b, 1'b1, 5'd10, 64'd0, 32'd0);
    chk("fail_code", 64'(o_trap_code), 64'd5);
    chk("fail_pass", 64'(o_pass), 64'd0);
    rec(64'h80000008, 32'h00000013, 1'b1, 5'd10, 64'd0, 32'd0);
    rec(64'h8000000c, 32'h00000013, 1'b0, 5'd0, 64'd0, 32'd3);
    idle();
    chk("frozen_instr", o_instr_cnt, 64'd2);
    chk("frozen_cycle", o_cycle_cnt, 64'd2);
    chk("frozen_pc", o_last_pc, 64'h80000004);
    i_gpr_raddr = 5'd10;
    idle();
    chk("a0_kept", o_gpr_rdata, 64'd5);

    // x0 stays zero, x31 readable one cycle later.
    reset_dut();
    rec(64'h80000000, 32'h00000013, 1'b1, 5'd0, 64'hDEAD, 32'd0);
    rec(64'h80000004, 32'h00000013, 1'b1, 5'd31, 64'h1234, 32'd0);
    i_gpr_raddr = 5'd0;
    idle();
    chk("x0_read", o_gpr_rdata, 64'd0);
    i_gpr_raddr = 5'd31;
    idle();
    chk("x31_read", o_gpr_rdata, 64'h1234);

    // Watchdog expiry after the LIM-th idle cycle.
    reset_dut();
    rec(64'h80000000, 32'h00000013, 1'b0, 5'd0, 64'd0, 32'd0);
    for (int i = 0; i < LIM - 1; i++) idle();
    chk("wd_before", 64'(o_timeout), 64'd0);
    idle();
    chk("wd_expire", 64'(o_timeout), 64'd1);
    chk("wd_running", 64'(o_running), 64'd0);

    // A record on idle cycle 7 restarts the count.
    reset_dut();
    rec(64'h80000000, 32'h00000013, 1'b0, 5'd0, 64'd0, 32'd0);
    for (int i = 0; i < LIM - 2; i++) idle();
    rec(64'h80000004, 32'h00000013, 1'b0, 5'd0, 64'd0, 32'd0);
    for (int i = 0; i < LIM - 1; i++) idle();
    chk("wd_restart", 64'(o_timeout), 64'd0);
    idle();
    chk("wd_restart_exp", 64'(o_timeout), 64'd1);

    // Interrupt record, trap opcode on an interrupt record, misaligned pc.
    reset_dut();
    rec(64'h80000010, 32'h0000006b, 1'b1, 5'd5, 64'd9, 32'd7);
    chk("intr_cnt", 64'(o_intr_cnt), 64'd1);
    chk("intr_instr", o_instr_cnt, 64'd0);
    chk("intr_pc", o_last_pc, 64'h80000010);
    chk("intr_notrap", 64'(o_done), 64'd0);
    rec(64'h80000002, 32'h00000013, 1'b0, 5'd0, 64'd0, 32'd0);
    chk("misalign", 64'(o_pc_misalign), 64'd1);

    // Randomized episodes with occasional mid-run asynchronous reset.
    for (int ep = 0; ep < 40; ep++) begin
      int vprob;
      int len;
      vprob = (ep % 4 == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(30, 95));
      len = int'($urandom_range(50, 250));
      reset_dut();
      for (int c = 0; c < len; c++) begin
        i_gpr_raddr = 5'($urandom_range(0, 31));
        if (ep % 5 == 4 && c == len / 2) reset_dut();
        if (int'($urandom_range(0, 99)) < vprob) begin
          logic [63:0] pc;
          logic [31:0] inst;
          logic [4:0]  wd;
          pc = {$urandom, $urandom};
          if ($urandom_range(0, 15) != 0) pc[1:0] = 2'b00;
          inst = $urandom;
          if ($urandom_range(0, 59) == 0) inst[6:0] = 7'h6b;
          wd = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
          rec(pc, inst, 1'($urandom_range(0, 1)), wd, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 255)) : 32'd0);
        end else begin
          idle();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
